mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and `regs_memwb`. It turns the memory op carried from EX into a data-memory request with byte enables and aligned store data, and runs a request/acknowledge handshake that stalls the pipeline for variable-latency memory. It captures load data so it is valid while the instruction occupies WB. It forwards ALU, multiply and writeback controls unchanged to MEM/WB.

## Interface
- No parameters; widths come from `mips_cpu_pkg` (`word_t` 32 b, `double_word_t` 64 b, `reg_enum` 5 b).
- Clock and reset are decided: one clock; reset is asynchronous and active-low.
- `cpu_clk_50M`  in  1  clock.
- `cpu_rst_n`  in  1  reset, asynchronous, active-low.
- `mem_i_memop`  in  `mem_op_enum`  memory op from EX/MEM; `MEM_NONE` when there is no access.
- `mem_i_alures`  in  32  effective address for memory ops, otherwise the ALU result.
- `mem_i_wdata`  in  32  store source register value.
- `mem_i_rfwe`, `mem_i_hilowe`, `mem_i_dm2rf`  in  1 each  writeback controls.
- `mem_i_rfwa`  in  `reg_enum`  destination register.
- `mem_i_mulres`  in  64  multiply result.
- `dm_req`  out  1  memory request.
- `dm_we`  out  1  write strobe.
- `dm_addr`  out  32  word address: `{alures[31:2],2'b00}`.
- `dm_be`  out  4  byte enables.
- `dm_wdata`  out  32  aligned store data.
- `dm_ack`  in  1  request accepted/completed.
- `dm_rdata`  in  32  read word, valid when `dm_ack` is high.
- `mem_stall_req`  out  1  hold IF..MEM and insert a bubble into MEM/WB.
- `mem_o_rfwe`, `mem_o_hilowe`, `mem_o_dm2rf`, `mem_o_rfwa`, `mem_o_mulres`, `mem_o_alures`  out  —  to MEM/WB.
- `mem_o_bytesel`  out  4  load byte lanes.
- `mem_o_loadsign`  out  1  sign-extend load.
- `mem_o_dmdout`  out  32  captured load word, valid in the instruction's WB cycle.
- `mem_o_adel`, `mem_o_ades`  out  1 each  load / store address error.

## Operation
- Misalignment rules:
  - LH/LHU/SH are misaligned when `addr[0]`=1.
  - LW/SW are misaligned when `addr[1:0]`≠0.
  - A misaligned access raises `adel` (loads) or `ades` (stores), issues no request, forces `mem_o_rfwe`=0 and does not stall.
- Byte enables:
  - B/BU: `4'b0001<<addr[1:0]`.
  - H/HU: `addr[1]` ? `1100` : `0011`.
  - W: `1111`.
- Store data: SB replicates byte[7:0] four times; SH replicates half[15:0] twice; SW passes through.
- `mem_o_bytesel` equals `dm_be` for loads and 0 otherwise. `mem_o_loadsign` is 1 for LB/LH only.
- FSM states:
  - IDLE: a valid aligned memory op drives `dm_req`=1 combinationally.
    - `dm_ack` in the same cycle: complete, stay IDLE.
    - Otherwise go to WAIT.
  - WAIT: `dm_req`, `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are held from the MEM inputs, which are frozen by the stall. On `dm_ack`: complete, return to IDLE.
- `mem_stall_req` = valid aligned op && !`dm_ack`, in both states.
- Completion of a load registers `dm_rdata` into `rdata_q`. `mem_o_dmdout` = `rdata_q`.
- While `mem_stall_req`=1, `mem_o_rfwe`, `mem_o_hilowe` and `mem_o_dm2rf` are forced to 0 so that MEM/WB receives a bubble.
- No other stall source exists in MEM; the instruction leaves MEM in its completion cycle.

## Timing
- Reset values:
  - state IDLE, `rdata_q`=0.
  - `dm_req`, `dm_we`, `mem_stall_req`, `adel`, `ades` all 0.
  - All `mem_o_*` controls 0; `mem_o_rfwa`=`REG_ZERO`.
  - Reset acts asynchronously, including mid-WAIT: the request drops immediately and the outstanding ack is ignored.
- Zero-wait memory: a load with ack in cycle N enters MEM/WB at edge N+1. `mem_o_dmdout` is valid during cycle N+1, which is the load's WB cycle, and it is stable until the next load completes.
- k wait cycles add exactly k stall cycles.
- Back-to-back loads each capture on their own ack. `rdata_q` updates at the same edge at which MEM/WB latches the next instruction.
- Stores write on the ack cycle; `dm_we`=1 only while `dm_req`=1.
- A `dm_ack` received while `dm_req`=0 is ignored.

## Structure
- Add to `mips_cpu_pkg`:
  - `mem_op_enum`: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
  - `mem_state_enum`: IDLE, WAIT.
- Combinational sub-module `mem_align` (op, addr, wdata → be, aligned wdata, misaligned flag, loadsign). The FSM, the capture register and the passthrough logic stay in `mem_stage`.

## Test plan
- LW at 0x100, ack in the same cycle → `dm_be`=1111, no stall; next cycle `mem_o_dmdout`=`dm_rdata`, `rfwe`=1.
- SB of 0x000000A5 to 0x103, ack after 2 cycles → `dm_be`=1000, `dm_wdata`=0xA5A5A5A5, `dm_we`=1; 2 stall cycles with MEM/WB controls 0.
- LH at 0x102 → `be`=1100, `loadsign`=1; LHU at 0x102 → `loadsign`=0.
- LW at 0x101 → `adel`=1, `dm_req`=0, `rfwe`=0, no stall; SH at 0x103 → `ades`=1.
- Assert `cpu_rst_n`=0 mid-WAIT → `dm_req` and `mem_stall_req` drop at once. A late ack after release changes nothing, and `rdata_q` stays 0.
- ALU op (`MEM_NONE`), `alures`=0x1234, `rfwe`=1 → passes through, `dm_req`=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mips_cpu_pkg
// Description : Shared types for the five-stage MIPS pipeline.
// Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_pkg;

    typedef logic [31:0] word_t;
    typedef logic [63:0] double_word_t;

    typedef enum logic [4:0] {
        REG_ZERO, REG_AT, REG_V0, REG_V1, REG_A0, REG_A1, REG_A2, REG_A3,
        REG_T0,   REG_T1, REG_T2, REG_T3, REG_T4, REG_T5, REG_T6, REG_T7,
        REG_S0,   REG_S1, REG_S2, REG_S3, REG_S4, REG_S5, REG_S6, REG_S7,
        REG_T8,   REG_T9, REG_K0, REG_K1, REG_GP, REG_SP, REG_FP, REG_RA
    } reg_enum;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_enum;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_enum;

    function automatic logic is_load_op(input mem_op_enum op);
        return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
               (op == MEM_LHU) || (op == MEM_LW);
    endfunction

    function automatic logic is_store_op(input mem_op_enum op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Byte enables, store-data lane replication, alignment check
//               and load sign selection for one memory op.
// Revision    : 1.0  initial release
// ============================================================================
module mem_align
    import mips_cpu_pkg::*;
(
    input  mips_cpu_pkg::mem_op_enum op,
    input  logic [1:0]               offset,
    input  logic [31:0]              wdata,
    output logic [3:0]               be,
    output logic [31:0]              wdata_aligned,
    output logic                     misaligned,
    output logic                     loadsign
);

    // Decode lanes per access size; stores replicate so the memory picks lanes by be
    always_comb begin
        be            = 4'b0000;
        wdata_aligned = wdata;
        misaligned    = 1'b0;
        loadsign      = 1'b0;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                be            = 4'b0001 << offset;
                wdata_aligned = {4{wdata[7:0]}};
                loadsign      = (op == MEM_LB);
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                be            = offset[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                misaligned    = offset[0];
                loadsign      = (op == MEM_LH);
            end
            MEM_LW, MEM_SW: begin
                be         = 4'b1111;
                misaligned = (offset != 2'b00);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS MEM stage: data-memory request/ack handshake with
//               pipeline stall, load-data capture and MEM/WB passthrough.
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage
    import mips_cpu_pkg::*;
(
    input  logic                       cpu_clk_50M,
    input  logic                       cpu_rst_n,
    input  mips_cpu_pkg::mem_op_enum   mem_i_memop,
    input  mips_cpu_pkg::word_t        mem_i_alures,
    input  mips_cpu_pkg::word_t        mem_i_wdata,
    input  logic                       mem_i_rfwe,
    input  logic                       mem_i_hilowe,
    input  logic                       mem_i_dm2rf,
    input  mips_cpu_pkg::reg_enum      mem_i_rfwa,
    input  mips_cpu_pkg::double_word_t mem_i_mulres,
    output logic                       dm_req,
    output logic                       dm_we,
    output mips_cpu_pkg::word_t        dm_addr,
    output logic [3:0]                 dm_be,
    output mips_cpu_pkg::word_t        dm_wdata,
    input  logic                       dm_ack,
    input  mips_cpu_pkg::word_t        dm_rdata,
    output logic                       mem_stall_req,
    output logic                       mem_o_rfwe,
    output logic                       mem_o_hilowe,
    output logic                       mem_o_dm2rf,
    output mips_cpu_pkg::reg_enum      mem_o_rfwa,
    output mips_cpu_pkg::double_word_t mem_o_mulres,
    output mips_cpu_pkg::word_t        mem_o_alures,
    output logic [3:0]                 mem_o_bytesel,
    output logic                       mem_o_loadsign,
    output mips_cpu_pkg::word_t        mem_o_dmdout,
    output logic                       mem_o_adel,
    output logic                       mem_o_ades
);

    mem_state_enum state;
    mem_state_enum state_next;
    word_t         rdata_q;

    logic [3:0]    align_be;
    word_t         align_wdata;
    logic          misaligned;
    logic          loadsign;
    logic          is_load;
    logic          is_store;
    logic          valid_op;
    logic          completes;

    mem_align u_align (
        .op            (mem_i_memop),
        .offset        (mem_i_alures[1:0]),
        .wdata         (mem_i_wdata),
        .be            (align_be),
        .wdata_aligned (align_wdata),
        .misaligned    (misaligned),
        .loadsign      (loadsign)
    );

    // Request decode; reset gates everything so an asserted reset drops the request at once
    always_comb begin
        is_load       = is_load_op(mem_i_memop);
        is_store      = is_store_op(mem_i_memop);
        valid_op      = cpu_rst_n && (is_load || is_store) && !misaligned;
        dm_req        = valid_op;
        dm_we         = valid_op && is_store;
        dm_addr       = {mem_i_alures[31:2], 2'b00};
        dm_be         = valid_op ? align_be : 4'b0000;
        dm_wdata      = align_wdata;
        completes     = valid_op && dm_ack;
        mem_stall_req = valid_op && !dm_ack;
    end

    // Next-state: wait until the outstanding request is acknowledged
    always_comb begin
        state_next = state;
        case (state)
            MEM_IDLE: if (dm_req && !dm_ack) state_next = MEM_WAIT;
            MEM_WAIT: if (dm_ack || !dm_req) state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    // Handshake state and load-data capture on completion
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state   <= MEM_IDLE;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (completes && is_load) begin
                rdata_q <= dm_rdata;
            end
        end
    end

    // MEM/WB passthrough; controls become a bubble while stalled or in reset
    always_comb begin
        mem_o_rfwe     = cpu_rst_n && mem_i_rfwe && !misaligned && !mem_stall_req;
        mem_o_hilowe   = cpu_rst_n && mem_i_hilowe && !mem_stall_req;
        mem_o_dm2rf    = cpu_rst_n && mem_i_dm2rf && !mem_stall_req;
        mem_o_rfwa     = cpu_rst_n ? mem_i_rfwa : REG_ZERO;
        mem_o_mulres   = cpu_rst_n ? mem_i_mulres : '0;
        mem_o_alures   = cpu_rst_n ? mem_i_alures : '0;
        mem_o_bytesel  = is_load ? dm_be : 4'b0000;
        mem_o_loadsign = cpu_rst_n && loadsign && is_load;
        mem_o_dmdout   = rdata_q;
        mem_o_adel     = cpu_rst_n && is_load && misaligned;
        mem_o_ades     = cpu_rst_n && is_store && misaligned;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage with directed scenarios
//               and a randomized run against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage;
    import mips_cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    mem_op_enum   memop;
    word_t        alures, wdata, dm_addr, dm_wdata, dm_rdata;
    word_t        o_alures, o_dmdout;
    logic         rfwe, hilowe, dm2rf;
    reg_enum      rfwa, o_rfwa;
    double_word_t mulres, o_mulres;
    logic         dm_req, dm_we, dm_ack, stall;
    logic [3:0]   dm_be, o_bytesel;
    logic         o_rfwe, o_hilowe, o_dm2rf, o_loadsign, o_adel, o_ades;

    int total = 0;
    int bad   = 0;
    word_t exp_rdata = 32'h0;

    always #10 clk = ~clk;

    mem_stage dut (
        .cpu_clk_50M    (clk),
        .cpu_rst_n      (rst_n),
        .mem_i_memop    (memop),
        .mem_i_alures   (alures),
        .mem_i_wdata    (wdata),
        .mem_i_rfwe     (rfwe),
        .mem_i_hilowe   (hilowe),
        .mem_i_dm2rf    (dm2rf),
        .mem_i_rfwa     (rfwa),
        .mem_i_mulres   (mulres),
        .dm_req         (dm_req),
        .dm_we          (dm_we),
        .dm_addr        (dm_addr),
        .dm_be          (dm_be),
        .dm_wdata       (dm_wdata),
        .dm_ack         (dm_ack),
        .dm_rdata       (dm_rdata),
        .mem_stall_req  (stall),
        .mem_o_rfwe     (o_rfwe),
        .mem_o_hilowe   (o_hilowe),
        .mem_o_dm2rf    (o_dm2rf),
        .mem_o_rfwa     (o_rfwa),
        .mem_o_mulres   (o_mulres),
        .mem_o_alures   (o_alures),
        .mem_o_bytesel  (o_bytesel),
        .mem_o_loadsign (o_loadsign),
        .mem_o_dmdout   (o_dmdout),
        .mem_o_adel     (o_adel),
        .mem_o_ades     (o_ades)
    );

    task automatic drive(input mem_op_enum op, input word_t a, input word_t d, input logic we);
        memop = op; alures = a; wdata = d; rfwe = we;
        hilowe = 1'b0; dm2rf = is_load_op(op);
        rfwa = REG_T0; mulres = 64'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(MEM_LW, 32'h100, 32'h0, 1'b1);
        hilowe = 1'b1; rfwa = REG_RA; dm_ack = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (dm_req !== 1'b0 || dm_we !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL reset_req req=%b we=%b stall=%b want 0", dm_req, dm_we, stall); end
        total++; if (o_rfwe !== 1'b0 || o_hilowe !== 1'b0 || o_dm2rf !== 1'b0 || o_rfwa !== REG_ZERO) begin bad++; $display("FAIL reset_ctrl rfwe=%b hilowe=%b dm2rf=%b rfwa=%0d want 0", o_rfwe, o_hilowe, o_dm2rf, o_rfwa); end
        total++; if (o_dmdout !== 32'h0 || o_adel !== 1'b0 || o_ades !== 1'b0) begin bad++; $display("FAIL reset_data dmdout=%h adel=%b ades=%b want 0", o_dmdout, o_adel, o_ades); end
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        exp_rdata = 32'h0;
        next_cycle();
    endtask

    task automatic test_lw_zero_wait();
        word_t rd;
        rd = $urandom;
        drive(MEM_LW, 32'h100, 32'h0, 1'b1);
        dm_ack = 1'b1; dm_rdata = rd;
        @(negedge clk);
        total++; if (dm_req !== 1'b1 || dm_be !== 4'b1111 || stall !== 1'b0 || dm_addr !== 32'h100) begin bad++; $display("FAIL lw_req req=%b be=%b stall=%b addr=%h want 1/1111/0/100", dm_req, dm_be, stall, dm_addr); end
        total++; if (o_rfwe !== 1'b1 || o_bytesel !== 4'b1111) begin bad++; $display("FAIL lw_ctrl rfwe=%b bytesel=%b want 1/1111", o_rfwe, o_bytesel); end
        next_cycle();
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
        dm_ack = 1'b0; dm_rdata = ~rd;
        @(negedge clk);
        total++; if (o_dmdout !== rd) begin bad++; $display("FAIL lw_data dmdout=%h want %h", o_dmdout, rd); end
        exp_rdata = rd;
        next_cycle();
    endtask

    task automatic test_sb_wait();
        int stalls = 0;
        drive(MEM_SB, 32'h103, 32'h000000A5, 1'b0);
        dm2rf = 1'b1; hilowe = 1'b1;
        for (int c = 0; c < 3; c++) begin
            dm_ack = (c == 2);
            @(negedge clk);
            if (stall === 1'b1) stalls++;
            total++; if (dm_req !== 1'b1 || dm_we !== 1'b1 || dm_be !== 4'b1000 || dm_wdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_req c=%0d req=%b we=%b be=%b wdata=%h want 1/1/1000/a5a5a5a5", c, dm_req, dm_we, dm_be, dm_wdata); end
            total++; if ((c < 2) && (o_hilowe !== 1'b0 || o_dm2rf !== 1'b0 || o_rfwe !== 1'b0)) begin bad++; $display("FAIL sb_bubble c=%0d hilowe=%b dm2rf=%b rfwe=%b want 0", c, o_hilowe, o_dm2rf, o_rfwe); end
            next_cycle();
        end
        total++; if (stalls !== 2) begin bad++; $display("FAIL sb_stalls stalls=%0d want 2", stalls); end
        dm_ack = 1'b0;
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_half_loads();
        drive(MEM_LH, 32'h102, 32'h0, 1'b1);
        dm_ack = 1'b1;
        @(negedge clk);
        total++; if (dm_be !== 4'b1100 || o_loadsign !== 1'b1 || o_bytesel !== 4'b1100) begin bad++; $display("FAIL lh be=%b loadsign=%b bytesel=%b want 1100/1/1100", dm_be, o_loadsign, o_bytesel); end
        exp_rdata = dm_rdata;
        next_cycle();
        drive(MEM_LHU, 32'h102, 32'h0, 1'b1);
        @(negedge clk);
        total++; if (dm_be !== 4'b1100 || o_loadsign !== 1'b0) begin bad++; $display("FAIL lhu be=%b loadsign=%b want 1100/0", dm_be, o_loadsign); end
        exp_rdata = dm_rdata;
        next_cycle();
        dm_ack = 1'b0;
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_misaligned();
        drive(MEM_LW, 32'h101, 32'h0, 1'b1);
        dm_ack = 1'b0;
        @(negedge clk);
        total++; if (o_adel !== 1'b1 || o_ades !== 1'b0 || dm_req !== 1'b0 || o_rfwe !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL lw_mis adel=%b ades=%b req=%b rfwe=%b stall=%b want 1/0/0/0/0", o_adel, o_ades, dm_req, o_rfwe, stall); end
        next_cycle();
        drive(MEM_SH, 32'h103, 32'h0, 1'b0);
        @(negedge clk);
        total++; if (o_ades !== 1'b1 || o_adel !== 1'b0 || dm_req !== 1'b0 || dm_we !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL sh_mis ades=%b adel=%b req=%b we=%b stall=%b want 1/0/0/0/0", o_ades, o_adel, dm_req, dm_we, stall); end
        next_cycle();
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        drive(MEM_LW, 32'h200, 32'h0, 1'b1);
        dm_ack = 1'b0; dm_rdata = 32'hDEADBEEF;
        next_cycle();
        @(negedge clk);
        total++; if (dm_req !== 1'b1 || stall !== 1'b1) begin bad++; $display("FAIL wait_pre req=%b stall=%b want 1/1", dm_req, stall); end
        rst_n = 1'b0;
        #1;
        total++; if (dm_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rst_drop req=%b stall=%b want 0/0", dm_req, stall); end
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
        dm_ack = 1'b1;
        next_cycle();
        dm_ack = 1'b0;
        @(negedge clk);
        total++; if (o_dmdout !== 32'h0 || dm_req !== 1'b0) begin bad++; $display("FAIL late_ack dmdout=%h req=%b want 0/0", o_dmdout, dm_req); end
        exp_rdata = 32'h0;
        next_cycle();
    endtask

    task automatic test_alu_pass();
        drive(MEM_NONE, 32'h1234, 32'h0, 1'b1);
        rfwa = REG_S3; mulres = 64'hCAFE_0000_1234_5678; hilowe = 1'b1;
        dm_ack = 1'b1;
        @(negedge clk);
        total++; if (o_alures !== 32'h1234 || o_rfwe !== 1'b1 || o_rfwa !== REG_S3 || o_hilowe !== 1'b1 || o_mulres !== 64'hCAFE_0000_1234_5678) begin bad++; $display("FAIL alu_pass alures=%h rfwe=%b rfwa=%0d hilowe=%b mulres=%h", o_alures, o_rfwe, o_rfwa, o_hilowe, o_mulres); end
        total++; if (dm_req !== 1'b0 || stall !== 1'b0 || o_bytesel !== 4'b0 || o_dmdout !== exp_rdata) begin bad++; $display("FAIL alu_noreq req=%b stall=%b bytesel=%b dmdout=%h want 0/0/0/%h", dm_req, stall, o_bytesel, o_dmdout, exp_rdata); end
        next_cycle();
        dm_ack = 1'b0;
    endtask

    // Random ops with random wait lengths, checked against arithmetic rules
    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            mem_op_enum op;
            word_t a, d;
            int size, off, k;
            logic ld, st, mis, we;
            logic [3:0] ebe;
            word_t ewd;
            op  = mem_op_enum'($urandom_range(0, 8));
            a   = $urandom; d = $urandom; we = 1'($urandom);
            ld  = (op >= MEM_LB) && (op <= MEM_LW);
            st  = (op >= MEM_SB);
            size = (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 1 :
                   (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 4;
            off = int'(a % 4);
            mis = (ld || st) && (off % size != 0);
            ebe = 4'(((1 << size) - 1) << (off - off % size));
            ewd = (size == 1) ? d[7:0] * 32'h01010101 :
                  (size == 2) ? d[15:0] * 32'h00010001 : d;
            k   = (ld || st) && !mis ? $urandom_range(0, 3) : 0;
            drive(op, a, d, we);
            for (int c = 0; c <= k; c++) begin
                logic req_e, ack;
                req_e = (ld || st) && !mis;
                ack = req_e ? (c == k) : 1'($urandom);
                dm_ack = ack; dm_rdata = $urandom;
                @(negedge clk);
                total++; if (dm_req !== req_e || stall !== (req_e && !ack) || (req_e && dm_be !== ebe) || dm_we !== (req_e && st)) begin bad++; $display("FAIL rnd_req n=%0d op=%0d a=%h req=%b stall=%b be=%b we=%b want %b/%b/%b/%b", n, op, a, dm_req, stall, dm_be, dm_we, req_e, req_e && !ack, ebe, req_e && st); end
                total++; if (o_rfwe !== (we && !mis && !(req_e && !ack)) || o_adel !== (ld && mis) || o_ades !== (st && mis) || o_dmdout !== exp_rdata) begin bad++; $display("FAIL rnd_out n=%0d rfwe=%b adel=%b ades=%b dmdout=%h want dmdout %h", n, o_rfwe, o_adel, o_ades, o_dmdout, exp_rdata); end
                total++; if (req_e && st && dm_wdata !== ewd) begin bad++; $display("FAIL rnd_wdata n=%0d wdata=%h want %h", n, dm_wdata, ewd); end
                if (req_e && ack && ld) exp_rdata = dm_rdata;
                next_cycle();
            end
        end
        dm_ack = 1'b0;
        drive(MEM_NONE, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        dm_ack = 1'b0; dm_rdata = 32'h0;
        test_reset();
        test_lw_zero_wait();
        test_sb_wait();
        test_half_loads();
        test_misaligned();
        test_alu_pass();
        test_reset_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
